// File: rtl/dpram_pkg.sv
// dpram_pkg: shared types for the dual-port RAM.
// Holds controller state encoding and read-during-write modes.
package dpram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dp_state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/dpram_gen2_outpipe.sv
// dpram_gen2_outpipe: per-port read data / VALID output stage.
// Ports: clk_i, rst_ni, vld_i, data_i in; vld_o, data_o out.
module dpram_gen2_outpipe #(
  parameter int DATA    = 16,
  parameter int OUT_REG = 0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            vld_i,
  input  logic [DATA-1:0] data_i,
  output logic            vld_o,
  output logic [DATA-1:0] data_o
);

  logic            s1_vld_q;
  logic [DATA-1:0] s1_data_q;

  // Data only moves with VALID so the output holds between reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
    end else begin
      s1_vld_q <= vld_i;
      if (vld_i) s1_data_q <= data_i;
    end
  end

  if (OUT_REG != 0) begin : g_reg
    logic            s2_vld_q;
    logic [DATA-1:0] s2_data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        s2_vld_q  <= 1'b0;
        s2_data_q <= '0;
      end else begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) s2_data_q <= s1_data_q;
      end
    end

    assign vld_o  = s2_vld_q;
    assign data_o = s2_data_q;
  end else begin : g_noreg
    assign vld_o  = s1_vld_q;
    assign data_o = s1_data_q;
  end

endmodule

// File: rtl/dpram_gen2.sv
// dpram_gen2: true dual-port RAM with byte enables and power-up clear.
// Ports: clK, rst_n, a/b_port_{EN,WR,BE,ADDR,data_IN} in; a/b_port_{data_OUT,VALID}, init_BUSY, coll_ERR out.
module dpram_gen2
  import dpram_pkg::*;
#(
  parameter int              DATA     = 16,
  parameter int              ADDR     = 5,
  parameter int              RDW_MODE = 0,
  parameter int              OUT_REG  = 0,
  parameter logic [DATA-1:0] CLR_VAL  = '0
) (
  input  logic              clK,
  input  logic              rst_n,
  output logic              init_BUSY,
  output logic              coll_ERR,
  input  logic              a_port_EN,
  input  logic              a_port_WR,
  input  logic [DATA/8-1:0] a_port_BE,
  input  logic [ADDR-1:0]   a_port_ADDR,
  input  logic [DATA-1:0]   a_port_data_IN,
  output logic [DATA-1:0]   a_port_data_OUT,
  output logic              a_port_VALID,
  input  logic              b_port_EN,
  input  logic              b_port_WR,
  input  logic [DATA/8-1:0] b_port_BE,
  input  logic [ADDR-1:0]   b_port_ADDR,
  input  logic [DATA-1:0]   b_port_data_IN,
  output logic [DATA-1:0]   b_port_data_OUT,
  output logic              b_port_VALID
);

  localparam int NBE   = DATA / 8;
  localparam int DEPTH = 2 ** ADDR;

  function automatic logic [DATA-1:0] be_merge(
    input logic [DATA-1:0] old_w,
    input logic [DATA-1:0] new_w,
    input logic [NBE-1:0]  be
  );
    logic [DATA-1:0] r;
    r = old_w;
    for (int i = 0; i < NBE; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  logic [DATA-1:0] mem_q [DEPTH];

  dp_state_e       state_q, state_d;
  logic [ADDR-1:0] clr_addr_q, clr_addr_d;
  logic            clr_we, ready;
  logic            coll_q, coll_d;

  // Controller: state register
  always_ff @(posedge clK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Controller: next state
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR'(1);
        if (clr_addr_q == '1) state_d = READY;
      end
      READY: ;
      default: state_d = CLEAR;
    endcase
  end

  // Controller: outputs
  always_comb begin
    clr_we    = (state_q == CLEAR);
    ready     = (state_q == READY);
    init_BUSY = clr_we;
  end

  logic            a_rd, b_rd, a_we, b_we;
  logic            same, b_we_eff;
  logic [DATA-1:0] a_old, b_old;
  logic [DATA-1:0] a_wdat, b_wdat;
  logic [DATA-1:0] a_rdat, b_rdat;

  always_comb begin
    a_rd  = ready & a_port_EN;
    b_rd  = ready & b_port_EN;
    a_we  = a_rd & a_port_WR & (|a_port_BE);
    b_we  = b_rd & b_port_WR & (|b_port_BE);
    same  = (a_port_ADDR == b_port_ADDR);
    a_old = mem_q[a_port_ADDR];
    b_old = mem_q[b_port_ADDR];

    // A's word absorbs B's lanes on a shared address, A lanes on top.
    b_wdat   = be_merge(b_old, b_port_data_IN, b_port_BE);
    a_wdat   = be_merge((b_we && same) ? b_wdat : a_old,
                        a_port_data_IN, a_port_BE);
    b_we_eff = b_we & ~(a_we & same);
    coll_d   = a_we & b_we & same & (|(a_port_BE & b_port_BE));

    a_rdat = a_old;
    b_rdat = b_old;
    if (RDW_MODE == RDW_WRITE_FIRST) begin
      if (a_we)              a_rdat = a_wdat;
      else if (b_we && same) a_rdat = b_wdat;
      if (a_we && same)      b_rdat = a_wdat;
      else if (b_we)         b_rdat = b_wdat;
    end
  end

  always_ff @(posedge clK) begin
    if (clr_we) begin
      mem_q[clr_addr_q] <= CLR_VAL;
    end else begin
      if (a_we)     mem_q[a_port_ADDR] <= a_wdat;
      if (b_we_eff) mem_q[b_port_ADDR] <= b_wdat;
    end
  end

  always_ff @(posedge clK or negedge rst_n) begin
    if (!rst_n) coll_q <= 1'b0;
    else        coll_q <= coll_d;
  end

  assign coll_ERR = coll_q;

  dpram_gen2_outpipe #(
    .DATA    (DATA),
    .OUT_REG (OUT_REG)
  ) u_out_a (
    .clk_i  (clK),
    .rst_ni (rst_n),
    .vld_i  (a_rd),
    .data_i (a_rdat),
    .vld_o  (a_port_VALID),
    .data_o (a_port_data_OUT)
  );

  dpram_gen2_outpipe #(
    .DATA    (DATA),
    .OUT_REG (OUT_REG)
  ) u_out_b (
    .clk_i  (clK),
    .rst_ni (rst_n),
    .vld_i  (b_rd),
    .data_i (b_rdat),
    .vld_o  (b_port_VALID),
    .data_o (b_port_data_OUT)
  );

endmodule

// File: tb/tb_dpram_gen2.sv
// tb_dpram_gen2: checks dpram_gen2 in two builds sharing one stimulus:
// dut0 read-first/no out reg, dut1 write-first/out reg.
module tb_dpram_gen2;

  typedef struct {
    logic        aen;
    logic        awr;
    logic [1:0]  abe;
    logic [4:0]  aa;
    logic [15:0] ad;
    logic        ben;
    logic        bwr;
    logic [1:0]  bbe;
    logic [4:0]  ba;
    logic [15:0] bd;
    logic [15:0] ea_rf;
    logic [15:0] ea_wf;
    logic [15:0] eb_rf;
    logic [15:0] eb_wf;
    logic        coll;
  } vec_t;

  typedef struct {
    int          due;
    logic [15:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_en, a_wr, b_en, b_wr;
  logic [1:0]  a_be, b_be;
  logic [4:0]  a_addr, b_addr;
  logic [15:0] a_di, b_di;

  logic        busy0, coll0, a_v0, b_v0;
  logic [15:0] a_do0, b_do0;
  logic        busy1, coll1, a_v1, b_v1;
  logic [15:0] a_do1, b_do1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int coll_due = -1;

  exp_t q0a[$], q0b[$], q1a[$], q1b[$];
  vec_t tbl[13];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dpram_gen2 #(
    .DATA(16), .ADDR(5), .RDW_MODE(0),
    .OUT_REG(0), .CLR_VAL(16'h0000)
  ) dut0 (
    .clK(clk), .rst_n(rst_n),
    .init_BUSY(busy0), .coll_ERR(coll0),
    .a_port_EN(a_en), .a_port_WR(a_wr),
    .a_port_BE(a_be), .a_port_ADDR(a_addr),
    .a_port_data_IN(a_di), .a_port_data_OUT(a_do0),
    .a_port_VALID(a_v0),
    .b_port_EN(b_en), .b_port_WR(b_wr),
    .b_port_BE(b_be), .b_port_ADDR(b_addr),
    .b_port_data_IN(b_di), .b_port_data_OUT(b_do0),
    .b_port_VALID(b_v0)
  );

  dpram_gen2 #(
    .DATA(16), .ADDR(5), .RDW_MODE(1),
    .OUT_REG(1), .CLR_VAL(16'h0000)
  ) dut1 (
    .clK(clk), .rst_n(rst_n),
    .init_BUSY(busy1), .coll_ERR(coll1),
    .a_port_EN(a_en), .a_port_WR(a_wr),
    .a_port_BE(a_be), .a_port_ADDR(a_addr),
    .a_port_data_IN(a_di), .a_port_data_OUT(a_do1),
    .a_port_VALID(a_v1),
    .b_port_EN(b_en), .b_port_WR(b_wr),
    .b_port_BE(b_be), .b_port_ADDR(b_addr),
    .b_port_data_IN(b_di), .b_port_data_OUT(b_do1),
    .b_port_VALID(b_v1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic mon(input string nm, input logic v,
                     input logic [15:0] d, input int n,
                     input exp_t e, output bit pop);
    pop = 1'b0;
    tests++;
    if (v) begin
      if (n == 0) begin
        fails++;
        $display("FAIL %s: VALID with %h at cycle %0d, none expected",
                 nm, d, cyc);
      end else begin
        pop = 1'b1;
        if (e.due != cyc || e.d !== d) begin
          fails++;
          $display("FAIL %s: got %h at cycle %0d want %h at cycle %0d",
                   nm, d, cyc, e.d, e.due);
        end
      end
    end else if (n > 0 && e.due <= cyc) begin
      pop = 1'b1;
      fails++;
      $display("FAIL %s: no VALID at cycle %0d want %h", nm, cyc, e.d);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    exp_t dmy;
    bit   p;
    dmy = '{0, 16'h0};
    e = dmy; if (q0a.size() > 0) e = q0a[0];
    mon("rdA0", a_v0, a_do0, q0a.size(), e, p);
    if (p) void'(q0a.pop_front());
    e = dmy; if (q0b.size() > 0) e = q0b[0];
    mon("rdB0", b_v0, b_do0, q0b.size(), e, p);
    if (p) void'(q0b.pop_front());
    e = dmy; if (q1a.size() > 0) e = q1a[0];
    mon("rdA1", a_v1, a_do1, q1a.size(), e, p);
    if (p) void'(q1a.pop_front());
    e = dmy; if (q1b.size() > 0) e = q1b[0];
    mon("rdB1", b_v1, b_do1, q1b.size(), e, p);
    if (p) void'(q1b.pop_front());
    chk("coll0", 32'(coll0), 32'(cyc == coll_due));
    chk("coll1", 32'(coll1), 32'(cyc == coll_due));
  end

  function automatic vec_t mkrd(input logic ae, input logic [4:0] aa,
                                input logic [15:0] ea, input logic be,
                                input logic [4:0] ba,
                                input logic [15:0] eb);
    vec_t v;
    v = '{1'b0, 1'b0, 2'b00, 5'd0, 16'h0,
          1'b0, 1'b0, 2'b00, 5'd0, 16'h0,
          16'h0, 16'h0, 16'h0, 16'h0, 1'b0};
    v.aen = ae; v.aa = aa; v.ea_rf = ea; v.ea_wf = ea;
    v.ben = be; v.ba = ba; v.eb_rf = eb; v.eb_wf = eb;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    a_en = v.aen; a_wr = v.awr; a_be = v.abe;
    a_addr = v.aa; a_di = v.ad;
    b_en = v.ben; b_wr = v.bwr; b_be = v.bbe;
    b_addr = v.ba; b_di = v.bd;
    if (v.aen) begin
      q0a.push_back('{cyc + 1, v.ea_rf});
      q1a.push_back('{cyc + 2, v.ea_wf});
    end
    if (v.ben) begin
      q0b.push_back('{cyc + 1, v.eb_rf});
      q1b.push_back('{cyc + 2, v.eb_wf});
    end
    if (v.coll) coll_due = cyc + 1;
  endtask

  task automatic step(input vec_t v);
    drive(v);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(mkrd(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0));
  endtask

  task automatic rst_chk(input string nm);
    chk({nm, "_a0"}, {16'h0, a_do0}, 32'h0);
    chk({nm, "_b0"}, {16'h0, b_do0}, 32'h0);
    chk({nm, "_a1"}, {16'h0, a_do1}, 32'h0);
    chk({nm, "_b1"}, {16'h0, b_do1}, 32'h0);
    chk({nm, "_vld"}, 32'({a_v0, b_v0, a_v1, b_v1}), 32'h0);
    chk({nm, "_coll"}, 32'({coll0, coll1}), 32'h0);
    chk({nm, "_busy"}, 32'({busy0, busy1}), 32'h3);
  endtask

  task automatic busy_len(input string nm);
    int n;
    n = 0;
    while (busy0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n, 32);
    chk({nm, "_b1"}, 32'(busy1), 32'h0);
  endtask

  task automatic flush();
    q0a.delete(); q0b.delete();
    q1a.delete(); q1b.delete();
    coll_due = -1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    tbl[0]  = '{1'b1, 1'b1, 2'b11, 5'd3,  16'h1234,
                1'b0, 1'b0, 2'b00, 5'd0,  16'h0000,
                16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 2'b01, 5'd3,  16'hBEEF,
                1'b0, 1'b0, 2'b00, 5'd0,  16'h0000,
                16'h1234, 16'h12EF, 16'h0000, 16'h0000, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 2'b00, 5'd3,  16'h0000,
                1'b0, 1'b0, 2'b00, 5'd0,  16'h0000,
                16'h12EF, 16'h12EF, 16'h0000, 16'h0000, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 2'b00, 5'd0,  16'h0000,
                1'b1, 1'b1, 2'b11, 5'd7,  16'h5555,
                16'h0000, 16'h0000, 16'h0000, 16'h5555, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 2'b11, 5'd7,  16'hAAAA,
                1'b1, 1'b0, 2'b00, 5'd7,  16'h0000,
                16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 2'b00, 5'd7,  16'h0000,
                1'b1, 1'b1, 2'b10, 5'd7,  16'h0F0F,
                16'hAAAA, 16'h0FAA, 16'hAAAA, 16'h0FAA, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 2'b11, 5'd9,  16'h1111,
                1'b1, 1'b1, 2'b10, 5'd9,  16'h2222,
                16'h0000, 16'h1111, 16'h0000, 16'h1111, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 2'b00, 5'd9,  16'h0000,
                1'b1, 1'b0, 2'b00, 5'd7,  16'h0000,
                16'h1111, 16'h1111, 16'h0FAA, 16'h0FAA, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 2'b01, 5'd10, 16'h3344,
                1'b1, 1'b1, 2'b10, 5'd10, 16'h5566,
                16'h0000, 16'h5544, 16'h0000, 16'h5544, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 2'b00, 5'd10, 16'hFFFF,
                1'b1, 1'b0, 2'b00, 5'd3,  16'h0000,
                16'h5544, 16'h5544, 16'h12EF, 16'h12EF, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 2'b11, 5'd3,  16'h0000,
                1'b1, 1'b0, 2'b00, 5'd3,  16'h0000,
                16'h0000, 16'h0000, 16'h12EF, 16'h12EF, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 2'b10, 5'd13, 16'hABAB,
                1'b1, 1'b1, 2'b01, 5'd12, 16'hCDCD,
                16'h0000, 16'hAB00, 16'h0000, 16'h00CD, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 2'b00, 5'd12, 16'h0000,
                1'b1, 1'b0, 2'b00, 5'd13, 16'h0000,
                16'h00CD, 16'h00CD, 16'hAB00, 16'hAB00, 1'b0};

    rst_n = 1'b0;
    a_en = 1'b0; a_wr = 1'b0; a_be = 2'b00; a_addr = '0; a_di = '0;
    b_en = 1'b0; b_wr = 1'b0; b_be = 2'b00; b_addr = '0; b_di = '0;
    #3;
    rst_chk("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Requests during the clear must be ignored.
    a_en = 1'b1; a_wr = 1'b1; a_be = 2'b11;
    a_addr = 5'd0; a_di = 16'hFFFF;
    b_en = 1'b1; b_addr = 5'd31;
    busy_len("busy_len");
    a_en = 1'b0; a_wr = 1'b0; b_en = 1'b0;

    for (int i = 0; i < 32; i++)
      step(mkrd(1'b1, 5'(i), 16'h0, 1'b1, 5'(31 - i), 16'h0));

    for (int i = 0; i < 13; i++) step(tbl[i]);
    idle(3);

    // Outputs hold the last read result while idle.
    chk("hold_a0", {16'h0, a_do0}, 32'h00CD);
    chk("hold_b0", {16'h0, b_do0}, 32'hAB00);
    chk("hold_a1", {16'h0, a_do1}, 32'h00CD);
    chk("hold_b1", {16'h0, b_do1}, 32'hAB00);

    // Back-to-back reads: one VALID per cycle, fixed latency.
    step(mkrd(1'b1, 5'd3,  16'h12EF, 1'b0, 5'd0, 16'h0));
    step(mkrd(1'b1, 5'd7,  16'h0FAA, 1'b0, 5'd0, 16'h0));
    step(mkrd(1'b1, 5'd9,  16'h1111, 1'b0, 5'd0, 16'h0));
    step(mkrd(1'b1, 5'd10, 16'h5544, 1'b0, 5'd0, 16'h0));
    idle(3);

    // Reset while reads are in flight.
    drive(mkrd(1'b1, 5'd9, 16'h1111, 1'b1, 5'd7, 16'h0FAA));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    flush();
    a_en = 1'b0; b_en = 1'b0;
    #1;
    rst_chk("rst_rd");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    busy_len("busy_len2");

    // Reset in the middle of the clear.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_busy", 32'(busy0), 32'h1);
    rst_n = 1'b0;
    #1;
    rst_chk("rst_clr");
    @(negedge clk);
    rst_n = 1'b1;
    busy_len("busy_len3");

    step(mkrd(1'b1, 5'd3, 16'h0, 1'b1, 5'd9, 16'h0));
    idle(3);

    chk("sb_empty",
        q0a.size() + q0b.size() + q1a.size() + q1b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
